// File: rtl/bo_countdown.sv
// Datapath for the countdown multiplier: down-counter, accumulator and result
// capture on the controller's pronto rising edge.
module bo_countdown #(
  parameter int WIDTH = 8,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             rac,
  input  logic             dec,
  input  logic             cac,
  input  logic             pronto,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] step_in,
  output logic             zero,
  output logic [WIDTH-1:0] cnt,
  output logic [AW-1:0]    acc,
  output logic [AW-1:0]    result,
  output logic             result_valid,
  output logic             ovf,
  output logic             dec_err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             ovf_q, ovf_d;
  logic             dec_err_q, dec_err_d;
  logic             pronto_q;
  logic [AW:0]      sum;
  logic             capture;

  // Extra top bit of the sum carries the accumulator overflow.
  assign sum     = {1'b0, acc_q} + {{(AW + 1 - WIDTH){1'b0}}, step_in};
  assign capture = pronto & ~pronto_q;

  always_comb begin
    cnt_d     = cnt_q;
    dec_err_d = dec_err_q;
    if (set) begin
      cnt_d     = n_in;
      dec_err_d = 1'b0;
    end else if (dec) begin
      if (cnt_q == '0) begin
        dec_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (rac) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (cac) begin
      acc_d = sum[AW-1:0];
      if (sum[AW]) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Capture samples the accumulator as it stands before this edge's update.
  always_comb begin
    result_d       = capture ? acc_q : result_q;
    result_valid_d = capture;
  end

  // pronto_q resets high so the controller's idle pronto does not capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      dec_err_q      <= 1'b0;
      pronto_q       <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      dec_err_q      <= dec_err_d;
      pronto_q       <= pronto;
    end
  end

  assign zero         = (cnt_q == '0);
  assign cnt          = cnt_q;
  assign acc          = acc_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;
  assign dec_err      = dec_err_q;

endmodule

// File: tb/tb_bo_countdown.sv
// Self-checking bench for bo_countdown: integer reference model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_bo_countdown;

  localparam int WIDTH = 8;
  localparam int AW    = 16;
  localparam int MOD   = 1 << AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             set = 1'b0, rac = 1'b0, dec = 1'b0, cac = 1'b0;
  logic             pronto = 1'b1;
  logic [WIDTH-1:0] n_in = '0, step_in = '0;
  logic             zero, result_valid, ovf, dec_err;
  logic [WIDTH-1:0] cnt;
  logic [AW-1:0]    acc, result;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;
  bit checkEn = 1'b0;

  int mCnt = 0, mAcc = 0, mRes = 0;
  bit mValid = 0, mOvf = 0, mDecErr = 0, mPrevPronto = 1;

  bo_countdown #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .set(set), .rac(rac), .dec(dec), .cac(cac),
    .pronto(pronto), .n_in(n_in), .step_in(step_in), .zero(zero), .cnt(cnt),
    .acc(acc), .result(result), .result_valid(result_valid), .ovf(ovf),
    .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic d,
                               input logic c, input logic p,
                               input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] st);
    set = s; rac = r; dec = d; cac = c; pronto = p; n_in = n; step_in = st;
    @(posedge clk);
    #1;
  endtask

  // Reference model: multiplication-by-repeated-addition in plain integers.
  always @(posedge clk) begin
    int sumVal;
    if (rst) begin
      mCnt = 0; mAcc = 0; mRes = 0; mValid = 0; mOvf = 0; mDecErr = 0;
      mPrevPronto = 1;
    end else begin
      mValid = pronto && !mPrevPronto;
      if (mValid) mRes = mAcc;
      if (set) begin
        mCnt = int'(n_in);
        mDecErr = 0;
      end else if (dec) begin
        if (mCnt == 0) mDecErr = 1;
        else mCnt = mCnt - 1;
      end
      if (rac) begin
        mAcc = 0;
        mOvf = 0;
      end else if (cac) begin
        sumVal = mAcc + int'(step_in);
        if (sumVal >= MOD) mOvf = 1;
        mAcc = sumVal % MOD;
      end
      mPrevPronto = pronto;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("zero", 32'(zero), 32'(mCnt == 0));
      checkOutput("cnt", 32'(cnt), 32'(mCnt));
      checkOutput("acc", 32'(acc), 32'(mAcc));
      checkOutput("result", 32'(result), 32'(mRes));
      checkOutput("result_valid", 32'(result_valid), 32'(mValid));
      checkOutput("ovf", 32'(ovf), 32'(mOvf));
      checkOutput("dec_err", 32'(dec_err), 32'(mDecErr));
      if (result_valid === 1'b1) pulseCount++;
    end
  end

  initial begin
    // Reset with controller idle; everything must come out zero.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd0);
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd0);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_cnt", 32'(cnt), 32'd0);
    checkOutput("reset_acc", 32'(acc), 32'd0);
    checkOutput("reset_valid", 32'(result_valid), 32'd0);

    // n=3, step=5 controller-like sequence.
    pulseCount = 0;
    applyStimulus(1, 1, 0, 0, 1, 8'd3, 8'd5);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_zero_low", 32'(zero), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 8'd3, 8'd5);
      applyStimulus(0, 0, 1, 1, 0, 8'd3, 8'd5);
    end
    checkOutput("t1_zero_high", 32'(zero), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 8'd3, 8'd5);
    applyStimulus(0, 0, 0, 0, 1, 8'd3, 8'd5);
    checkOutput("t1_valid", 32'(result_valid), 32'd1);
    checkOutput("t1_result", 32'(result), 32'd15);
    checkOutput("t1_ovf", 32'(ovf), 32'd0);
    checkOutput("t1_dec_err", 32'(dec_err), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 8'd3, 8'd5);
    checkOutput("t1_valid_drop", 32'(result_valid), 32'd0);
    checkOutput("t1_pulses", 32'(pulseCount), 32'd1);

    // n=0: zero immediately, result 0, no pulse from post-reset idle.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd9);
    rst = 1'b0;
    pulseCount = 0;
    applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd9);
    checkOutput("t2_zero", 32'(zero), 32'd1);
    checkOutput("t2_no_idle_pulse", 32'(result_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 8'd9);
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd9);
    checkOutput("t2_valid", 32'(result_valid), 32'd1);
    checkOutput("t2_result", 32'(result), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd9);
    checkOutput("t2_pulses", 32'(pulseCount), 32'd1);

    // 300 x 255 overflows 16 bits: 76500 - 65536 = 10964.
    applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd255);
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, 1, 1, 8'd0, 8'd255);
    checkOutput("t3_acc", 32'(acc), 32'd10964);
    checkOutput("t3_ovf", 32'(ovf), 32'd1);
    applyStimulus(0, 1, 0, 0, 1, 8'd0, 8'd255);
    checkOutput("t3_acc_clr", 32'(acc), 32'd0);
    checkOutput("t3_ovf_clr", 32'(ovf), 32'd0);

    // Decrement past zero holds and flags; set clears the flag.
    applyStimulus(1, 0, 0, 0, 1, 8'd1, 8'd0);
    applyStimulus(0, 0, 1, 0, 1, 8'd1, 8'd0);
    checkOutput("t4_cnt0", 32'(cnt), 32'd0);
    checkOutput("t4_no_err", 32'(dec_err), 32'd0);
    applyStimulus(0, 0, 1, 0, 1, 8'd1, 8'd0);
    checkOutput("t4_cnt_hold", 32'(cnt), 32'd0);
    checkOutput("t4_err", 32'(dec_err), 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 8'd4, 8'd0);
    checkOutput("t4_cnt4", 32'(cnt), 32'd4);
    checkOutput("t4_err_clr", 32'(dec_err), 32'd0);

    // Priority: set over dec, rac over cac.
    applyStimulus(1, 1, 0, 0, 1, 8'd2, 8'd0);
    applyStimulus(0, 0, 0, 1, 1, 8'd2, 8'd20);
    checkOutput("t5_acc20", 32'(acc), 32'd20);
    applyStimulus(1, 0, 1, 0, 1, 8'd7, 8'd0);
    checkOutput("t5_set_prio", 32'(cnt), 32'd7);
    applyStimulus(0, 1, 0, 1, 1, 8'd7, 8'd3);
    checkOutput("t5_rac_prio", 32'(acc), 32'd0);

    // Reset mid-operation, coinciding with a pronto rise, must not capture.
    applyStimulus(1, 1, 0, 0, 1, 8'd4, 8'd5);
    applyStimulus(0, 0, 0, 0, 0, 8'd4, 8'd5);
    applyStimulus(0, 0, 1, 1, 0, 8'd4, 8'd5);
    applyStimulus(0, 0, 1, 1, 0, 8'd4, 8'd5);
    checkOutput("t6_cnt2", 32'(cnt), 32'd2);
    checkOutput("t6_acc10", 32'(acc), 32'd10);
    pulseCount = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 1, 1, 1, 8'd4, 8'd5);
    rst = 1'b0;
    checkOutput("t6_rst_cnt", 32'(cnt), 32'd0);
    checkOutput("t6_rst_acc", 32'(acc), 32'd0);
    checkOutput("t6_rst_valid", 32'(result_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 8'd4, 8'd5);
    checkOutput("t6_no_pulse", 32'(pulseCount), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 8'd4, 8'd5);
    applyStimulus(0, 0, 0, 0, 1, 8'd4, 8'd5);
    checkOutput("t6_late_valid", 32'(result_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 8'd4, 8'd5);
    checkOutput("t6_pulses", 32'(pulseCount), 32'd1);

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
